// File: rtl/simple_io_arbiter_if.sv
// Requester and reduction-unit signal bundle for simple_io_arbiter.
// The arbiter side uses the slave modport; the requester/unit environment uses master.
interface simple_io_arbiter_if;
  logic       req_1, req_2, req_3;
  logic [2:0] op_1, op_2, op_3;
  logic       ack_1, ack_2, ack_3;
  logic       done_1, done_2, done_3;
  logic       res_and, res_or;
  logic       unit_in_1, unit_in_2, unit_in_3;
  logic       unit_out_1, unit_out_2;

  modport slave (
    input  req_1, req_2, req_3, op_1, op_2, op_3, unit_out_1, unit_out_2,
    output ack_1, ack_2, ack_3, done_1, done_2, done_3, res_and, res_or,
           unit_in_1, unit_in_2, unit_in_3
  );

  modport master (
    output req_1, req_2, req_3, op_1, op_2, op_3, unit_out_1, unit_out_2,
    input  ack_1, ack_2, ack_3, done_1, done_2, done_3, res_and, res_or,
           unit_in_1, unit_in_2, unit_in_3
  );
endinterface

// File: rtl/simple_io_arbiter.sv
// Round-robin sequencer sharing one 3-input AND/OR unit among three requesters:
// grant, drive operand, wait SETTLE_CYCLES, capture results and pulse done to the owner.
module simple_io_arbiter #(
  parameter int SETTLE_CYCLES = 1
) (
  input logic               clock,
  input logic               reset,
  simple_io_arbiter_if.slave bus
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DRIVE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  logic [1:0] r_state;
  logic [3:0] r_count;
  logic [1:0] r_owner;
  logic [1:0] r_last;
  logic [2:0] r_ack;
  logic [2:0] r_done;
  logic [2:0] r_unit_in;
  logic       r_res_and;
  logic       r_res_or;

  logic [2:0] w_req;
  logic [1:0] w_cand0;
  logic [1:0] w_cand1;
  logic       w_grant_valid;
  logic [1:0] w_grant;
  logic [2:0] w_grant_op;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  assign w_req   = {bus.req_3, bus.req_2, bus.req_1};
  assign w_cand0 = next_idx(r_last);
  assign w_cand1 = next_idx(w_cand0);

  // Indices are 0-based internally; r_last itself is the lowest-priority candidate.
  always_comb begin
    w_grant_valid = |w_req;
    w_grant       = r_last;
    if (w_req[w_cand0]) begin
      w_grant = w_cand0;
    end else if (w_req[w_cand1]) begin
      w_grant = w_cand1;
    end
  end

  always_comb begin
    case (w_grant)
      2'd0:    w_grant_op = bus.op_1;
      2'd1:    w_grant_op = bus.op_2;
      default: w_grant_op = bus.op_3;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_count   <= 4'd0;
      r_owner   <= 2'd0;
      r_last    <= 2'd2;
      r_ack     <= 3'b000;
      r_done    <= 3'b000;
      r_unit_in <= 3'b000;
      r_res_and <= 1'b0;
      r_res_or  <= 1'b0;
    end else begin
      r_ack  <= 3'b000;
      r_done <= 3'b000;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_unit_in <= w_grant_op;
            r_ack     <= 3'b001 << w_grant;
            r_count   <= SETTLE_INIT;
            r_owner   <= w_grant;
            r_last    <= w_grant;
            r_state   <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          r_count <= r_count - 4'd1;
          // The unit has seen the operand for SETTLE_CYCLES edges by now.
          if (r_count == 4'd1) begin
            r_res_and <= bus.unit_out_1;
            r_res_or  <= bus.unit_out_2;
            r_done    <= 3'b001 << r_owner;
            r_state   <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack_1     = r_ack[0];
  assign bus.ack_2     = r_ack[1];
  assign bus.ack_3     = r_ack[2];
  assign bus.done_1    = r_done[0];
  assign bus.done_2    = r_done[1];
  assign bus.done_3    = r_done[2];
  assign bus.res_and   = r_res_and;
  assign bus.res_or    = r_res_or;
  assign bus.unit_in_1 = r_unit_in[0];
  assign bus.unit_in_2 = r_unit_in[1];
  assign bus.unit_in_3 = r_unit_in[2];
endmodule

// File: tb/tb_simple_io_arbiter.sv
// Bench for simple_io_arbiter: two instances (SETTLE_CYCLES 1 and 4) driven by directed and
// random traffic; a timeline model predicts ack/done events that a monitor pops and compares.
module tb_simple_io_arbiter;
  localparam int NI = 2;

  typedef struct packed {
    int         cyc;
    logic       is_done;
    logic [2:0] who;
    logic [2:0] op;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst_v     [NI];
  logic [2:0] req_v     [NI];
  logic [2:0] op_v      [NI][3];
  logic [2:0] ack_v     [NI];
  logic [2:0] done_v    [NI];
  logic [2:0] uin_v     [NI];
  logic       res_and_v [NI];
  logic       res_or_v  [NI];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb [NI][64];
  int   sb_rd [NI];
  int   sb_wr [NI];
  int   last_m [NI];
  int   nf_m [NI];

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      simple_io_arbiter_if bus ();
      assign bus.req_1 = req_v[gi][0];
      assign bus.req_2 = req_v[gi][1];
      assign bus.req_3 = req_v[gi][2];
      assign bus.op_1  = op_v[gi][0];
      assign bus.op_2  = op_v[gi][1];
      assign bus.op_3  = op_v[gi][2];
      assign bus.unit_out_1 = bus.unit_in_1 & bus.unit_in_2 & bus.unit_in_3;
      assign bus.unit_out_2 = bus.unit_in_1 | bus.unit_in_2 | bus.unit_in_3;
      assign ack_v[gi]     = {bus.ack_3, bus.ack_2, bus.ack_1};
      assign done_v[gi]    = {bus.done_3, bus.done_2, bus.done_1};
      assign uin_v[gi]     = {bus.unit_in_3, bus.unit_in_2, bus.unit_in_1};
      assign res_and_v[gi] = bus.res_and;
      assign res_or_v[gi]  = bus.res_or;

      simple_io_arbiter #(.SETTLE_CYCLES(gi == 0 ? 1 : 4)) dut (
        .clock (clock),
        .reset (rst_v[gi]),
        .bus   (bus)
      );
    end
  endgenerate

  function automatic int settle(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // Model: a grant is possible once the previous operation's slot has elapsed.
  initial begin
    int w;
    int c;
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      sb_rd[i] = 0; sb_wr[i] = 0; last_m[i] = 3; nf_m[i] = 0;
    end
    forever begin
      @(posedge clock);
      cyc++;
      for (int i = 0; i < NI; i++) begin
        if (rst_v[i]) begin
          sb_rd[i]  = sb_wr[i];
          last_m[i] = 3;
          nf_m[i]   = cyc + 1;
        end else if (cyc >= nf_m[i] && req_v[i] != 3'b000) begin
          w = 0;
          for (int k = 3; k >= 1; k--) begin
            c = ((last_m[i] + k - 1) % 3) + 1;
            if (req_v[i][c-1]) w = c;
          end
          e.cyc = cyc; e.is_done = 1'b0; e.who = 3'(1 << (w - 1)); e.op = op_v[i][w-1];
          sb[i][sb_wr[i] % 64] = e; sb_wr[i]++;
          e.cyc = cyc + settle(i); e.is_done = 1'b1;
          sb[i][sb_wr[i] % 64] = e; sb_wr[i]++;
          nf_m[i]   = cyc + settle(i) + 2;
          last_m[i] = w;
        end
      end
    end
  end

  // Monitor: pops an expectation whenever an ack or done pulse is presented.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      for (int i = 0; i < NI; i++) begin
        while (sb_rd[i] != sb_wr[i] && sb[i][sb_rd[i] % 64].cyc < cyc) begin
          e = sb[i][sb_rd[i] % 64];
          n_checks++; n_fail++;
          $display("FAIL dut%0d missing_event: cycle %0d no pulse, expected done=%0b who=%b", i, e.cyc, e.is_done, e.who);
          sb_rd[i]++;
        end
        if ((ack_v[i] | done_v[i]) != 3'b000) begin
          n_checks++;
          if (sb_rd[i] == sb_wr[i] || sb[i][sb_rd[i] % 64].cyc != cyc) begin
            n_fail++;
            $display("FAIL dut%0d unexpected_pulse: cycle %0d ack=%b done=%b, expected none", i, cyc, ack_v[i], done_v[i]);
          end else begin
            e = sb[i][sb_rd[i] % 64];
            sb_rd[i]++;
            if (!e.is_done) begin
              if (ack_v[i] != e.who || done_v[i] != 3'b000 || uin_v[i] != e.op) begin
                n_fail++;
                $display("FAIL dut%0d ack_event: got ack=%b done=%b unit=%b, expected ack=%b done=000 unit=%b", i, ack_v[i], done_v[i], uin_v[i], e.who, e.op);
              end
            end else begin
              if (done_v[i] != e.who || ack_v[i] != 3'b000 || res_and_v[i] != (&e.op) ||
                  res_or_v[i] != (|e.op) || uin_v[i] != e.op) begin
                n_fail++;
                $display("FAIL dut%0d done_event: got done=%b ack=%b and=%b or=%b unit=%b, expected done=%b and=%b or=%b unit=%b",
                         i, done_v[i], ack_v[i], res_and_v[i], res_or_v[i], uin_v[i], e.who, &e.op, |e.op, e.op);
              end
            end
          end
        end
      end
    end
  end

  task automatic chk(input int i, input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL dut%0d %s: got %0d expected %0d", i, name, act, exp_v);
    end
  endtask

  task automatic check_zero(input int i, input string name);
    chk(i, name, int'({ack_v[i], done_v[i], res_and_v[i], res_or_v[i], uin_v[i]}), 0);
  endtask

  task automatic wait_any(input int i, output logic [2:0] got);
    int t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (ack_v[i] == 3'b000 && t < 200);
    got = ack_v[i];
    if (got == 3'b000) begin
      n_checks++; n_fail++;
      $display("FAIL dut%0d ack_timeout: got no ack within 200 cycles, expected an ack", i);
    end
  endtask

  task automatic idle(input int i);
    repeat (settle(i) + 4) @(negedge clock);
  endtask

  task automatic run_seq(input int i);
    logic [2:0] got;
    int s;
    int prev;
    int order [5] = '{1, 2, 4, 1, 2};
    s = settle(i);
    check_zero(i, "reset_state");
    rst_v[i] = 1'b0;

    op_v[i][0] = 3'b111; req_v[i][0] = 1'b1;
    wait_any(i, got); chk(i, "single1_ack", int'(got), 1); req_v[i][0] = 1'b0;
    chk(i, "single1_unit", int'(uin_v[i]), 7);
    idle(i);
    op_v[i][1] = 3'b000; req_v[i][1] = 1'b1;
    wait_any(i, got); chk(i, "single2_ack", int'(got), 2); req_v[i][1] = 1'b0;
    idle(i);
    op_v[i][2] = 3'b010; req_v[i][2] = 1'b1;
    wait_any(i, got); chk(i, "single3_ack", int'(got), 4); req_v[i][2] = 1'b0;
    idle(i);

    op_v[i][0] = 3'b001; op_v[i][1] = 3'b110; op_v[i][2] = 3'b101;
    req_v[i] = 3'b111;
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      wait_any(i, got);
      chk(i, "rr_order", int'(got), order[n]);
      if (n > 0) chk(i, "rr_spacing", cyc - prev, s + 2);
      prev = cyc;
    end
    req_v[i] = 3'b000;
    idle(i);

    // Abort in DRIVE: no done, outputs cleared, priority back to requester 1.
    op_v[i][1] = 3'b011; req_v[i][1] = 1'b1;
    wait_any(i, got); chk(i, "abort_ack", int'(got), 2);
    rst_v[i] = 1'b1;
    @(negedge clock);
    check_zero(i, "abort_zero");
    op_v[i][0] = 3'b100; req_v[i][0] = 1'b1; rst_v[i] = 1'b0;
    wait_any(i, got); chk(i, "prio_after_reset", int'(got), 1); req_v[i][0] = 1'b0;
    wait_any(i, got); chk(i, "second_after_reset", int'(got), 2); req_v[i][1] = 1'b0;
    idle(i);

    op_v[i][0] = 3'b011; req_v[i][0] = 1'b1;
    wait_any(i, got); chk(i, "late_op_ack", int'(got), 1);
    op_v[i][0] = 3'b111; req_v[i][0] = 1'b0;
    repeat (s) @(negedge clock);
    chk(i, "late_op_done", int'(done_v[i]), 1);
    chk(i, "late_op_res", int'({res_and_v[i], res_or_v[i]}), 1);
    idle(i);

    op_v[i][0] = 3'($urandom); req_v[i][0] = 1'b1;
    wait_any(i, got); chk(i, "busy_ack", int'(got), 1);
    req_v[i][0] = 1'b0; req_v[i][1] = 1'b1; req_v[i][2] = 1'b1;
    @(negedge clock);
    req_v[i][1] = 1'b0;
    wait_any(i, got); chk(i, "withdrawn_skip", int'(got), 4);
    req_v[i][2] = 1'b0;
    idle(i);

    repeat (400) begin
      @(negedge clock);
      rst_v[i] = ($urandom_range(0, 149) == 0);
      for (int k = 0; k < 3; k++) begin
        op_v[i][k] = 3'($urandom);
        if (req_v[i][k]) begin
          if (ack_v[i][k] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0))
            req_v[i][k] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req_v[i][k] = 1'b1;
        end
      end
    end
    rst_v[i] = 1'b0;
    req_v[i] = 3'b000;
    idle(i);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst_v[i] = 1'b1;
      req_v[i] = 3'b000;
      for (int k = 0; k < 3; k++) op_v[i][k] = 3'b000;
    end
    repeat (3) @(negedge clock);
    fork
      run_seq(0);
      run_seq(1);
    join
    repeat (10) @(negedge clock);
    for (int i = 0; i < NI; i++) chk(i, "scoreboard_drained", sb_wr[i] - sb_rd[i], 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
